// File: rtl/cic_interp.sv
// CIC interpolator: N low-rate combs, zero-stuffing by R, N high-rate integrators, 16-bit output.
// Optional build macro CIC_INTERP_ROUND_EN selects round-half-up with positive saturation instead of floor.
module cic_interp #(
    parameter int Win = 16,
    parameter int Wg  = 11,
    parameter int N   = 2,
    parameter int R   = 2000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic signed [Win-1:0] i_data,
    input  logic                  val_in,
    output logic                  rdy,
    output logic                  val_out,
    output logic signed [15:0]    o_data_trunc
);

    localparam int W  = Win + Wg;
    localparam int PW = $clog2(R);
    localparam logic [PW-1:0] PH_LAST = PW'(R - 1);

    logic signed [W-1:0] r_dly [N];
    logic signed [W-1:0] r_int [N];
    logic signed [W-1:0] r_c;
    logic                r_busy;
    logic                r_first;
    logic [PW-1:0]       r_ph;
    logic [N-1:0]        r_vs;

    logic signed [W-1:0] w_comb [N+1];
    logic signed [W-1:0] w_stuff;
    logic [N:0]          w_v;
    logic                w_accept;

    // Combs run at the full internal width so that comb growth wraps exactly like the integrators.
    always_comb begin
        w_comb[0] = {{Wg{i_data[Win-1]}}, i_data};
        for (int k = 1; k <= N; k++) begin
            w_comb[k] = w_comb[k-1] - r_dly[k-1];
        end
    end

    assign rdy      = !r_busy || (r_ph == PH_LAST);
    assign w_accept = val_in && rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                r_dly[k] <= '0;
            end
            r_c <= '0;
        end else if (w_accept) begin
            for (int k = 0; k < N; k++) begin
                r_dly[k] <= w_comb[k];
            end
            r_c <= w_comb[N];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_first <= 1'b0;
            r_ph    <= '0;
        end else if (w_accept) begin
            r_busy  <= 1'b1;
            r_first <= 1'b1;
            r_ph    <= '0;
        end else if (r_busy) begin
            r_first <= 1'b0;
            if (r_ph == PH_LAST) begin
                r_busy <= 1'b0;
                r_ph   <= '0;
            end else begin
                r_ph <= r_ph + 1'b1;
            end
        end
    end

    assign w_stuff = r_first ? r_c : '0;
    assign w_v     = {r_vs, r_busy};

    // Each integrator holds whenever its input valid bit is low, so idle gaps freeze the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vs <= '0;
            for (int k = 0; k < N; k++) begin
                r_int[k] <= '0;
            end
        end else begin
            r_vs <= w_v[N-1:0];
            if (w_v[0]) begin
                r_int[0] <= r_int[0] + w_stuff;
            end
            for (int k = 1; k < N; k++) begin
                if (w_v[k]) begin
                    r_int[k] <= r_int[k] + r_int[k-1];
                end
            end
        end
    end

    assign val_out = w_v[N];

`ifdef CIC_INTERP_ROUND_EN
    logic [16:0] w_top;
    logic        w_ovf;

    // Adding 2^(Wg-1) before slicing is the same as adding the first discarded bit to the slice.
    assign w_top = {r_int[N-1][W-1], r_int[N-1][W-1 -: 16]} + 17'(r_int[N-1][Wg-1]);
    assign w_ovf = !w_top[16] && w_top[15];
    assign o_data_trunc = w_ovf ? 16'sh7fff : w_top[15:0];
`else
    assign o_data_trunc = r_int[N-1][W-1 -: 16];
`endif

endmodule

// File: tb/tb_cic_interp.sv
// Bench for cic_interp: small instance (R=4, N=2, Wg=2) for sequence tests, default instance for DC gain.
// Reference model: zero-stuffed input convolved with the boxcar^N impulse response, wrapped and scaled.
module tb_cic_interp;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] d4, dd;
    logic               v4_in, vd_in;
    logic               rdy4, rdyd, vo4, vod;
    logic signed [15:0] o4, od;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int          in_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int          vcyc_q[$];
    int          acc_q[$];
    logic [15:0] gotd_q[$];

    cic_interp #(.Win(16), .Wg(2), .N(2), .R(4)) u_small (
        .clk(clk), .rst(rst), .i_data(d4), .val_in(v4_in),
        .rdy(rdy4), .val_out(vo4), .o_data_trunc(o4)
    );

    cic_interp u_dflt (
        .clk(clk), .rst(rst), .i_data(dd), .val_in(vd_in),
        .rdy(rdyd), .val_out(vod), .o_data_trunc(od)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vo4 === 1'b1) begin
            got_q.push_back(o4);
            vcyc_q.push_back(cyc);
        end
        if (vod === 1'b1) gotd_q.push_back(od);
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void build_exp(input int r, input int nst, input int wg, input int w);
        longint h[$];
        longint t[$];
        longint full, y, v;
        h.delete();
        h.push_back(1);
        repeat (nst) begin
            t.delete();
            for (int i = 0; i < h.size() + r - 1; i++) t.push_back(0);
            for (int i = 0; i < h.size(); i++)
                for (int j = 0; j < r; j++) t[i+j] += h[i];
            h = t;
        end
        full = longint'(1) << w;
        exp_q.delete();
        for (int m = 0; m < in_q.size() * r; m++) begin
            y = 0;
            for (int j = 0; j < in_q.size(); j++) begin
                int idx;
                idx = m - j * r;
                if (idx >= 0 && idx < h.size()) y += longint'(in_q[j]) * h[idx];
            end
            y = ((y % full) + full) % full;
            if (y >= full / 2) y -= full;
`ifdef CIC_INTERP_ROUND_EN
            y += longint'(1) << (wg - 1);
            if (y > full / 2 - 1) v = 32767;
            else v = y >>> wg;
`else
            v = y >>> wg;
`endif
            exp_q.push_back(16'(v));
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        v4_in = 1'b0;
        vd_in = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        got_q.delete();
        vcyc_q.delete();
        acc_q.delete();
        gotd_q.delete();
    endtask

    task automatic drive_small(input int period);
        for (int i = 0; i < in_q.size(); i++) begin
            @(negedge clk);
            d4 = 16'(in_q[i]);
            v4_in = 1'b1;
            acc_q.push_back(cyc + 1);
            @(negedge clk);
            v4_in = 1'b0;
            repeat (period - 2) @(negedge clk);
        end
        repeat (12) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v4_in = 1'b1;
        vd_in = 1'b1;
        d4 = 16'sd123;
        dd = 16'sd123;
        repeat (3) @(negedge clk);
        n_checks++; if (rdy4 !== 1'b1) begin n_fail++; $display("FAIL reset_rdy got=%b want=1", rdy4); end
        n_checks++; if (vo4 !== 1'b0) begin n_fail++; $display("FAIL reset_val_out got=%b want=0", vo4); end
        n_checks++; if (o4 !== 16'sd0) begin n_fail++; $display("FAIL reset_data got=%0d want=0", o4); end
        n_checks++; if (vod !== 1'b0) begin n_fail++; $display("FAIL reset_val_out_dflt got=%b want=0", vod); end
        n_checks++; if (od !== 16'sd0) begin n_fail++; $display("FAIL reset_data_dflt got=%0d want=0", od); end
        v4_in = 1'b0;
        vd_in = 1'b0;
        rst = 1'b0;
        got_q.delete();
        gotd_q.delete();
        repeat (10) @(negedge clk);
        #1;
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL reset_no_accept got=%0d outputs want=0", got_q.size()); end
        n_checks++; if (rdy4 !== 1'b1) begin n_fail++; $display("FAIL reset_rdy_after got=%b want=1", rdy4); end
    endtask

    task automatic test_impulse();
        logic [15:0] imp_ref [12];
        imp_ref = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        do_reset();
        in_q = '{4, 0, 0};
        drive_small(4);
        n_checks++; if (got_q.size() != 12) begin n_fail++; $display("FAIL impulse_count got=%0d want=12", got_q.size()); end
        for (int i = 0; i < 12 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== imp_ref[i]) begin n_fail++; $display("FAIL impulse_data[%0d] got=%0d want=%0d", i, $signed(got_q[i]), $signed(imp_ref[i])); end
        end
        if (got_q.size() > 0) begin
            n_checks++;
            if (vcyc_q[0] != acc_q[0] + 2) begin n_fail++; $display("FAIL impulse_latency got=%0d want=%0d", vcyc_q[0] - acc_q[0], 2); end
            n_checks++;
            if (vcyc_q[vcyc_q.size()-1] != vcyc_q[0] + vcyc_q.size() - 1) begin
                n_fail++; $display("FAIL impulse_gapless got_span=%0d want=%0d", vcyc_q[vcyc_q.size()-1] - vcyc_q[0], vcyc_q.size() - 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        in_q.delete();
        for (int i = 0; i < 10; i++) in_q.push_back(int'($urandom_range(0, 65535)) - 32768);
        build_exp(4, 2, 2, 18);
        drive_small(4);
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_data[%0d] got=%0d want=%0d", i, $signed(got_q[i]), $signed(exp_q[i])); end
        end
        for (int i = 1; i < vcyc_q.size(); i++) begin
            n_checks++;
            if (vcyc_q[i] != vcyc_q[i-1] + 1) begin n_fail++; $display("FAIL b2b_gapless[%0d] got_step=%0d want=1", i, vcyc_q[i] - vcyc_q[i-1]); end
        end
    endtask

    task automatic test_busy_drop();
        do_reset();
        in_q = '{4};
        build_exp(4, 2, 2, 18);
        @(negedge clk);
        d4 = 16'sd4;
        v4_in = 1'b1;
        @(negedge clk);
        n_checks++; if (rdy4 !== 1'b0) begin n_fail++; $display("FAIL busy_rdy got=%b want=0", rdy4); end
        d4 = 16'sd1000;
        @(negedge clk);
        v4_in = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL busy_count got=%0d want=4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL busy_data[%0d] got=%0d want=%0d", i, $signed(got_q[i]), $signed(exp_q[i])); end
        end
    endtask

    task automatic test_gap();
        do_reset();
        in_q.delete();
        for (int i = 0; i < 4; i++) in_q.push_back(int'($urandom_range(0, 65535)) - 32768);
        build_exp(4, 2, 2, 18);
        drive_small(6);
        n_checks++; if (got_q.size() != 16) begin n_fail++; $display("FAIL gap_count got=%0d want=16", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL gap_data[%0d] got=%0d want=%0d", i, $signed(got_q[i]), $signed(exp_q[i])); end
        end
        for (int i = 1; i < vcyc_q.size(); i++) begin
            int want;
            want = (i % 4 == 0) ? 3 : 1;
            n_checks++;
            if (vcyc_q[i] - vcyc_q[i-1] != want) begin n_fail++; $display("FAIL gap_step[%0d] got=%0d want=%0d", i, vcyc_q[i] - vcyc_q[i-1], want); end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [15:0] imp_ref [12];
        imp_ref = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        do_reset();
        @(negedge clk);
        d4 = 16'sd4;
        v4_in = 1'b1;
        @(negedge clk);
        v4_in = 1'b0;
        #1;
        for (int k = 0; k < 20 && got_q.size() < 3; k++) begin
            @(negedge clk);
            #1;
        end
        n_checks++; if (got_q.size() != 3) begin n_fail++; $display("FAIL midrst_wait got=%0d outputs want=3", got_q.size()); end
        rst = 1'b1;
        #1;
        n_checks++; if (vo4 !== 1'b0) begin n_fail++; $display("FAIL midrst_val_out got=%b want=0", vo4); end
        n_checks++; if (o4 !== 16'sd0) begin n_fail++; $display("FAIL midrst_data got=%0d want=0", o4); end
        @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        vcyc_q.delete();
        acc_q.delete();
        repeat (8) @(negedge clk);
        #1;
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL midrst_no_resume got=%0d outputs want=0", got_q.size()); end
        n_checks++; if (rdy4 !== 1'b1) begin n_fail++; $display("FAIL midrst_rdy got=%b want=1", rdy4); end
        in_q = '{4, 0, 0};
        drive_small(4);
        n_checks++; if (got_q.size() != 12) begin n_fail++; $display("FAIL midrst_count got=%0d want=12", got_q.size()); end
        for (int i = 0; i < 12 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== imp_ref[i]) begin n_fail++; $display("FAIL midrst_data[%0d] got=%0d want=%0d", i, $signed(got_q[i]), $signed(imp_ref[i])); end
        end
    endtask

    task automatic test_dc(input int level, input int want);
        int nbad;
        nbad = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dd = 16'(level);
            vd_in = 1'b1;
            @(negedge clk);
            vd_in = 1'b0;
            repeat (1998) @(negedge clk);
        end
        repeat (12) @(negedge clk);
        #1;
        n_checks++; if (gotd_q.size() != 8000) begin n_fail++; $display("FAIL dc_count(%0d) got=%0d want=8000", level, gotd_q.size()); end
        for (int i = 4000; i < 8000 && i < gotd_q.size(); i++) begin
            n_checks++;
            if ($signed(gotd_q[i]) != want) begin
                n_fail++;
                nbad++;
                if (nbad <= 5) $display("FAIL dc_data(%0d)[%0d] got=%0d want=%0d", level, i, $signed(gotd_q[i]), want);
            end
        end
    endtask

    initial begin
        d4 = '0;
        dd = '0;
        v4_in = 1'b0;
        vd_in = 1'b0;
        test_reset();
        test_impulse();
        test_back_to_back();
        test_busy_drop();
        test_gap();
        test_reset_mid_burst();
`ifdef CIC_INTERP_ROUND_EN
        test_dc(1000, 977);
`else
        test_dc(1000, 976);
`endif
        test_dc(-1000, -977);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
